instr_mem_loader: RTL

- Program memory that feeds the Instruction bus of the 8-bit core. The core presents Read_Address (its PC) and this block returns the instruction byte.
- Also provides a board-level load mode. The user sets a byte on the switches and presses a button to write it at an auto-incrementing address; the core is held off during loading.
- Runs on the fast board clock, not the divided 1 Hz core clock.

---
 rtl/instr_mem_loader_if.sv | 33 +++
 rtl/instr_mem_loader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader_if.sv
// ----------------------------------------------------------------------------
// instr_mem_loader_if
// Bus between the board/core side and the instruction memory loader.
//   LOAD_MODE    : raw slide switch, 1 = load mode
//   WR_BTN       : raw (bouncy) write push button
//   DATA_IN      : instruction byte from the switches
//   Read_Address : program counter from the core
//   Instruction  : registered instruction byte for Read_Address
//   Load_Addr    : next address to be written while loading
//   CPU_Hold     : holds the core off while loading
//   Full         : every word has been written in this load session
// master = board/core side, slave = the loader itself.
// ----------------------------------------------------------------------------
interface instr_mem_loader_if;
  logic       LOAD_MODE;
  logic       WR_BTN;
  logic [7:0] DATA_IN;
  logic [7:0] Read_Address;
  logic [7:0] Instruction;
  logic [7:0] Load_Addr;
  logic       CPU_Hold;
  logic       Full;

  modport master (
    output LOAD_MODE, WR_BTN, DATA_IN, Read_Address,
    input  Instruction, Load_Addr, CPU_Hold, Full
  );

  modport slave (
    input  LOAD_MODE, WR_BTN, DATA_IN, Read_Address,
    output Instruction, Load_Addr, CPU_Hold, Full
  );
endinterface

// File: rtl/instr_mem_loader.sv
// ----------------------------------------------------------------------------
// instr_mem_loader
// Program memory feeding the 8-bit core's instruction bus, with a board-level
// load mode: the user sets a byte on the switches and presses a debounced
// button to write it at an auto-incrementing address while the core is held.
// Runs entirely on the fast board clock.
//   CLK : board clock, rising edge
//   RST : asynchronous reset, active low
//   bus : instr_mem_loader_if slave modport (switch/button inputs, core PC in,
//         instruction, load address, hold and full flags out)
// ----------------------------------------------------------------------------
module instr_mem_loader #(
  parameter int unsigned DEPTH           = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [7:0]  FILL_WORD       = 8'h00
) (
  input  logic                     CLK,
  input  logic                     RST,
  instr_mem_loader_if.slave        bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [8:0]    DEPTH9  = 9'(DEPTH);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_LOAD = 2'd1,
    S_FULL = 2'd2
  } state_t;

  logic [1:0]    loadSync_q;
  logic [1:0]    btnSync_q;
  logic          loadMode;
  logic          btnLevel_q;
  logic          btnLevel_d;
  logic [CW-1:0] dbCnt_q;
  logic [CW-1:0] dbCnt_d;
  logic          pressPulse;

  state_t        state_q;
  logic [8:0]    loadAddr_q;
  logic [8:0]    loadAddrInc;
  logic          cpuHold_q;
  logic          full_q;
  logic          writeEn;
  logic [AW-1:0] wrIdx;
  logic [AW-1:0] rdIdx;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    instr_q;
  logic [7:0]    instr_d;

  // Both raw board inputs go through two flops before any logic looks at them.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      loadSync_q <= '0;
      btnSync_q  <= '0;
    end else begin
      loadSync_q <= {loadSync_q[0], bus.LOAD_MODE};
      btnSync_q  <= {btnSync_q[0], bus.WR_BTN};
    end
  end

  assign loadMode = loadSync_q[1];

  // Debouncer: the counter only runs while the synchronized button disagrees
  // with the accepted level, so any bounce back clears it. After
  // DEBOUNCE_CYCLES consecutive disagreeing samples the accepted level flips;
  // only a rising flip counts as a press, which is why a button already held
  // down when load mode starts cannot write until it is released first.
  always_comb begin
    dbCnt_d    = '0;
    btnLevel_d = btnLevel_q;
    pressPulse = 1'b0;
    if (btnSync_q[1] != btnLevel_q) begin
      if (dbCnt_q == DB_LAST) begin
        btnLevel_d = btnSync_q[1];
        pressPulse = btnSync_q[1];
      end else begin
        dbCnt_d = dbCnt_q + 1'b1;
      end
    end
  end

  // Debouncer state registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      btnLevel_q <= 1'b0;
      dbCnt_q    <= '0;
    end else begin
      btnLevel_q <= btnLevel_d;
      dbCnt_q    <= dbCnt_d;
    end
  end

  // A write needs a press while still loading; if the switch drops in the
  // same cycle the mode change wins and the press is lost.
  assign writeEn     = (state_q == S_LOAD) && loadMode && pressPulse;
  assign loadAddrInc = loadAddr_q + 9'd1;
  assign wrIdx       = loadAddr_q[AW-1:0];

  // Load-mode state machine with registered hold/full flags. Load_Addr is
  // kept after leaving load mode so the display still shows how many words
  // went in; it is only re-zeroed on the next entry into load mode.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_RUN;
      loadAddr_q <= '0;
      cpuHold_q  <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (loadMode) begin
            state_q    <= S_LOAD;
            loadAddr_q <= '0;
            cpuHold_q  <= 1'b1;
            full_q     <= 1'b0;
          end
        end
        S_LOAD: begin
          if (!loadMode) begin
            state_q   <= S_RUN;
            cpuHold_q <= 1'b0;
            full_q    <= 1'b0;
          end else if (pressPulse) begin
            loadAddr_q <= loadAddrInc;
            if (loadAddrInc == DEPTH9) begin
              state_q <= S_FULL;
              full_q  <= 1'b1;
            end
          end
        end
        S_FULL: begin
          if (!loadMode) begin
            state_q   <= S_RUN;
            cpuHold_q <= 1'b0;
            full_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_RUN;
          cpuHold_q <= 1'b0;
          full_q    <= 1'b0;
        end
      endcase
    end
  end

  // Instruction storage; every word returns to FILL_WORD on reset so a reset
  // in the middle of loading leaves no half-written program behind.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= FILL_WORD;
      end
    end else if (writeEn) begin
      mem_q[wrIdx] <= bus.DATA_IN;
    end
  end

  // Addresses past the end of the memory read back as FILL_WORD.
  assign rdIdx   = bus.Read_Address[AW-1:0];
  assign instr_d = ({1'b0, bus.Read_Address} < DEPTH9) ? mem_q[rdIdx] : FILL_WORD;

  // Registered read port; it sees the memory before any same-cycle write,
  // so a freshly written word shows up one cycle later.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      instr_q <= FILL_WORD;
    end else begin
      instr_q <= instr_d;
    end
  end

  assign bus.Instruction = instr_q;
  assign bus.Load_Addr   = loadAddr_q[7:0];
  assign bus.CPU_Hold    = cpuHold_q;
  assign bus.Full        = full_q;

endmodule
